sdrio_tx_sequencer: RTL and testbench

- Sequences the 4:1 output serializer of one SDR I/O lane clocked on geclk_ol.
- Generates the one-cycle parallel-load (update) strobe at a programmable phase and applies bit-slip alignment on request.
- Runs a write-burst FSM that drives the per-bit output-enable frame, including preamble and postamble, and pulls data frames from the fabric through a valid/ready handshake.
- Sits between the PHY write path and the IOC/GPIO primitives. Replaces the free-running update counter.

---
 rtl/sdrio_tx_sequencer_pkg.sv | 15 +
 rtl/sdrio_tx_sequencer_if.sv | 9 +
 rtl/sdrio_tx_sequencer_phase_gen.sv | 56 +++++
 rtl/sdrio_tx_sequencer.sv | 97 +++++++++
 tb/tb_sdrio_tx_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/sdrio_tx_sequencer_pkg.sv
// Shared encodings and constants for the SDR I/O lane transmit sequencer.
package sdrio_seq_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    BURST = 2'd2,
    POST  = 2'd3
  } seq_state_e;

  localparam int RATIO = 4;
  localparam int CNT_W = 2;

  localparam logic [RATIO-1:0] OEN_DRIVE = 4'hF;
  localparam logic [RATIO-1:0] OEN_OFF   = 4'h0;
endpackage

// File: rtl/sdrio_tx_sequencer_if.sv
// Fabric write-frame handshake between the PHY write path and the sequencer.
interface sdrio_tx_sequencer_if;
  logic wr_valid;
  logic wr_last;
  logic wr_ready;

  modport master (output wr_valid, output wr_last, input wr_ready);
  modport slave  (input wr_valid, input wr_last, output wr_ready);
endinterface

// File: rtl/sdrio_tx_sequencer_phase_gen.sv
// Frame phase counter, programmable update strobe and bit-slip guard timer.
module sdrio_phase_gen
  import sdrio_seq_pkg::*;
#(
  parameter int UPD_PHASE_RST = 2,
  parameter int SLIP_GUARD    = 4
) (
  input  logic             geclk_ol,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_upd_phase,
  input  logic             idle,
  input  logic             align_req,
  output logic             slip_acc,
  output logic             align_busy,
  output logic             align_done,
  output logic             align_rej,
  output logic [1:0]       slip_cnt,
  output logic             upd_strobe
);
  localparam int GW = $clog2(SLIP_GUARD + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] phase_r;
  logic             hold_r;
  logic [GW-1:0]    guard;

  assign align_busy = (guard != '0);
  assign slip_acc   = align_req && idle && !align_busy;

  always_ff @(posedge geclk_ol or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      phase_r    <= CNT_W'(UPD_PHASE_RST);
      hold_r     <= 1'b0;
      guard      <= '0;
      slip_cnt   <= '0;
      align_done <= 1'b0;
      align_rej  <= 1'b0;
      upd_strobe <= 1'b0;
    end else begin
      hold_r <= slip_acc;
      if (!hold_r) cnt <= cnt + CNT_W'(1);
      // The held count repeats once; gating the hold cycle keeps one strobe per frame.
      upd_strobe <= (cnt == phase_r) && !hold_r;
      if (idle && !align_busy) phase_r <= cfg_upd_phase;
      if (slip_acc) begin
        guard    <= GW'(SLIP_GUARD);
        slip_cnt <= slip_cnt + 2'd1;
      end else if (align_busy) begin
        guard <= guard - GW'(1);
      end
      align_done <= (guard == GW'(1));
      align_rej  <= align_req && !slip_acc;
    end
  end
endmodule

// File: rtl/sdrio_tx_sequencer.sv
// Write-burst sequencer for one SDR I/O lane: update strobe, bit slip, OE framing.
module sdrio_tx_sequencer
  import sdrio_seq_pkg::*;
#(
  parameter int UPD_PHASE_RST = 2,
  parameter int PRE_FRAMES    = 1,
  parameter int POST_FRAMES   = 1,
  parameter int SLIP_GUARD    = 4
) (
  input  logic                 geclk_ol,
  input  logic                 rst,
  input  logic [CNT_W-1:0]     cfg_upd_phase,
  input  logic                 align_req,
  output logic                 align_busy,
  output logic                 align_done,
  output logic                 align_rej,
  output logic [1:0]           slip_cnt,
  output logic                 upd_strobe,
  sdrio_tx_sequencer_if.slave  wr,
  output logic [RATIO-1:0]     oen_t,
  output logic                 underrun,
  output logic [1:0]           state
);
  seq_state_e st;
  logic [1:0] pre_cnt;
  logic [1:0] post_cnt;
  logic       slip_acc;

  sdrio_phase_gen #(
    .UPD_PHASE_RST (UPD_PHASE_RST),
    .SLIP_GUARD    (SLIP_GUARD)
  ) u_phase (
    .geclk_ol      (geclk_ol),
    .rst           (rst),
    .cfg_upd_phase (cfg_upd_phase),
    .idle          (st == IDLE),
    .align_req     (align_req),
    .slip_acc      (slip_acc),
    .align_busy    (align_busy),
    .align_done    (align_done),
    .align_rej     (align_rej),
    .slip_cnt      (slip_cnt),
    .upd_strobe    (upd_strobe)
  );

  assign state       = st;
  assign wr.wr_ready = upd_strobe && (st == BURST);

  always_ff @(posedge geclk_ol or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      oen_t    <= OEN_OFF;
      pre_cnt  <= '0;
      post_cnt <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (upd_strobe) begin
        case (st)
          IDLE: begin
            // A slip accepted on this same strobe takes priority over starting a burst.
            if (wr.wr_valid && !align_busy && !slip_acc) begin
              st      <= PRE;
              oen_t   <= OEN_DRIVE;
              pre_cnt <= 2'(PRE_FRAMES - 1);
            end
          end
          PRE: begin
            if (pre_cnt == '0) st <= BURST;
            else               pre_cnt <= pre_cnt - 2'd1;
          end
          BURST: begin
            if (!wr.wr_valid) begin
              st       <= POST;
              post_cnt <= 2'(POST_FRAMES - 1);
              underrun <= 1'b1;
            end else if (wr.wr_last) begin
              st       <= POST;
              post_cnt <= 2'(POST_FRAMES - 1);
            end
          end
          POST: begin
            if (post_cnt != '0) begin
              post_cnt <= post_cnt - 2'd1;
            end else if (wr.wr_valid) begin
              st <= BURST;
            end else begin
              st    <= IDLE;
              oen_t <= OEN_OFF;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sdrio_tx_sequencer.sv
// Directed vector bench for sdrio_tx_sequencer: strobe phase, slips, bursts, conflicts.
module tb_sdrio_tx_sequencer;
  import sdrio_seq_pkg::*;

  logic       geclk_ol = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cfg_upd_phase = 2'd2;
  logic       align_req = 1'b0;
  logic       align_busy, align_done, align_rej, upd_strobe, underrun;
  logic [1:0] slip_cnt, state;
  logic [3:0] oen_t;

  int vec_n = 0;
  int miss  = 0;
  int cyc   = 0;

  always #5 geclk_ol = ~geclk_ol;

  sdrio_tx_sequencer_if wr_bus();

  sdrio_tx_sequencer #(
    .UPD_PHASE_RST (2),
    .PRE_FRAMES    (1),
    .POST_FRAMES   (1),
    .SLIP_GUARD    (4)
  ) dut (
    .geclk_ol      (geclk_ol),
    .rst           (rst),
    .cfg_upd_phase (cfg_upd_phase),
    .align_req     (align_req),
    .align_busy    (align_busy),
    .align_done    (align_done),
    .align_rej     (align_rej),
    .slip_cnt      (slip_cnt),
    .upd_strobe    (upd_strobe),
    .wr            (wr_bus),
    .oen_t         (oen_t),
    .underrun      (underrun),
    .state         (state)
  );

  typedef struct {
    logic       v;
    logic       l;
    logic       rdy;
    logic [1:0] st;
    logic [3:0] oen;
    logic       un;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic v, logic l, logic rdy, logic [1:0] st, logic [3:0] oen, logic un);
    vec_t r;
    r.v = v; r.l = l; r.rdy = rdy; r.st = st; r.oen = oen; r.un = un;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(negedge geclk_ol);
    cyc++;
  endtask

  // Called one cycle before a strobe; returns one cycle before the strobe after next.
  task automatic slip_once(input logic [1:0] exp_cnt);
    align_req = 1'b1;
    for (int d = 1; d <= 9; d++) begin
      step();
      align_req = 1'b0;
      chk("slip_strobe", 4'(upd_strobe), 4'(d == 1 || d == 6));
      chk("slip_busy",   4'(align_busy), 4'(d >= 1 && d <= 4));
      chk("slip_done",   4'(align_done), 4'(d == 5));
      chk("slip_cnt",    4'(slip_cnt),   4'(exp_cnt));
      if (d == 1) chk("slip_rej", 4'(align_rej), 4'h0);
    end
  endtask

  initial begin
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_last  = 1'b0;

    // burst of 3 frames
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 2'd1, 4'hF, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 2'd2, 4'hF, 1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b1, 2'd2, 4'hF, 1'b0);
    tbl[3]  = mk(1'b1, 1'b0, 1'b1, 2'd2, 4'hF, 1'b0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b1, 2'd3, 4'hF, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
    // underrun after one transfer
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, 2'd1, 4'hF, 1'b0);
    tbl[8]  = mk(1'b1, 1'b0, 1'b0, 2'd2, 4'hF, 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, 1'b1, 2'd2, 4'hF, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 2'd3, 4'hF, 1'b1);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
    // back-to-back bursts through POST
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 2'd1, 4'hF, 1'b0);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 2'd2, 4'hF, 1'b0);
    tbl[14] = mk(1'b1, 1'b1, 1'b1, 2'd3, 4'hF, 1'b0);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 2'd2, 4'hF, 1'b0);
    tbl[16] = mk(1'b1, 1'b1, 1'b1, 2'd3, 4'hF, 1'b0);
    tbl[17] = mk(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);

    repeat (2) @(negedge geclk_ol);
    rst = 1'b0;
    cyc = 0;

    for (int k = 0; k <= 10; k++) begin
      if (k > 0) step();
      chk("rst_strobe", 4'(upd_strobe), 4'(k == 3 || k == 7));
      chk("rst_state",  4'(state),      4'h0);
      chk("rst_oen",    oen_t,          4'h0);
      if (k == 0) begin
        chk("rst_busy",  4'(align_busy),      4'h0);
        chk("rst_done",  4'(align_done),      4'h0);
        chk("rst_rej",   4'(align_rej),       4'h0);
        chk("rst_slip",  4'(slip_cnt),        4'h0);
        chk("rst_ready", 4'(wr_bus.wr_ready), 4'h0);
        chk("rst_under", 4'(underrun),        4'h0);
      end
    end

    slip_once(2'd1);
    slip_once(2'd2);
    slip_once(2'd3);
    slip_once(2'd0);

    for (int i = 0; i < 18; i++) begin
      wr_bus.wr_valid = tbl[i].v;
      wr_bus.wr_last  = tbl[i].l;
      step();
      chk("tbl_strobe", 4'(upd_strobe),      4'h1);
      chk("tbl_ready",  4'(wr_bus.wr_ready), 4'(tbl[i].rdy));
      step();
      chk("tbl_state",  4'(state),    4'(tbl[i].st));
      chk("tbl_oen",    oen_t,        tbl[i].oen);
      chk("tbl_under",  4'(underrun), 4'(tbl[i].un));
      step();
      chk("tbl_under_pulse", 4'(underrun), 4'h0);
      step();
    end

    // slip and wr_valid together on an IDLE strobe
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_last  = 1'b0;
    rst = 1'b1;
    @(negedge geclk_ol);
    rst = 1'b0;
    cyc = 0;
    repeat (3) step();
    chk("prec_strobe3", 4'(upd_strobe), 4'h1);
    align_req = 1'b1;
    wr_bus.wr_valid = 1'b1;
    step();
    align_req = 1'b0;
    chk("prec_state4", 4'(state),      4'h0);
    chk("prec_busy4",  4'(align_busy), 4'h1);
    chk("prec_slip4",  4'(slip_cnt),   4'h1);
    for (int k = 5; k <= 7; k++) begin
      step();
      chk("prec_idle",   4'(state),      4'h0);
      chk("prec_nostrb", 4'(upd_strobe), 4'h0);
    end
    step();
    chk("prec_done8",   4'(align_done), 4'h1);
    chk("prec_strobe8", 4'(upd_strobe), 4'h1);
    chk("prec_state8",  4'(state),      4'h0);
    step();
    chk("prec_pre9", 4'(state), 4'h1);
    chk("prec_oen9", oen_t,     4'hF);

    // align_req and a phase change while in BURST
    repeat (3) step();
    chk("conf_strobe12", 4'(upd_strobe), 4'h1);
    step();
    chk("conf_burst13", 4'(state), 4'h2);
    align_req = 1'b1;
    cfg_upd_phase = 2'd0;
    step();
    align_req = 1'b0;
    chk("conf_rej14",    4'(align_rej),  4'h1);
    chk("conf_slip14",   4'(slip_cnt),   4'h1);
    chk("conf_busy14",   4'(align_busy), 4'h0);
    chk("conf_strobe14", 4'(upd_strobe), 4'h0);
    step();
    chk("conf_rej15",    4'(align_rej),  4'h0);
    chk("conf_strobe15", 4'(upd_strobe), 4'h0);
    step();
    chk("conf_strobe16", 4'(upd_strobe),      4'h1);
    chk("conf_ready16",  4'(wr_bus.wr_ready), 4'h1);
    step();
    chk("conf_burst17", 4'(state), 4'h2);
    chk("conf_oen17",   oen_t,     4'hF);

    // asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_oen",    oen_t,              4'h0);
    chk("mid_rst_state",  4'(state),          4'h0);
    chk("mid_rst_slip",   4'(slip_cnt),       4'h0);
    chk("mid_rst_strobe", 4'(upd_strobe),     4'h0);
    chk("mid_rst_ready",  4'(wr_bus.wr_ready), 4'h0);

    #10;
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss);
    $finish;
  end
endmodule
